sccb_write_master: RTL and testbench



---
 rtl/sccb_pkg.sv | 29 ++
 rtl/sccb_qtr_tick.sv | 40 ++++
 rtl/sccb_write_master.sv | 229 ++++++++++++++++++++++
 tb/tb_sccb_write_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB (I2C-style) register write engine.
// Holds FSM state codes, quarter-phase indices, the OV5640 write address
// and the default timing/size parameters used by sccb_write_master.
package sccb_pkg;

  // Default clk_25M cycles per quarter SCL period (63 -> ~99.2 kHz SCL).
  localparam int unsigned QTR_DIV_DEF   = 63;
  // Default bytes per write: device address, register hi, register lo, data.
  localparam int unsigned NUM_BYTES_DEF = 4;

  // OV5640 7-bit address 0x3C with the write bit appended.
  localparam logic [7:0] OV5640_WR_ADDR = 8'h78;

  // FSM state codes.
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Quarter-phase indices within one SCL period.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage : sccb_pkg

// File: rtl/sccb_qtr_tick.sv
// Quarter-bit timebase for the SCCB engine.
// Counts 0..QTR_DIV-1 while enabled and emits a registered one-cycle tick
// each time the count wraps. clr forces the count back to zero.
//   clk_25M     : system clock
//   camera_rstn : asynchronous active-low reset
//   en          : count enable (high while a transaction is on the bus)
//   clr         : synchronous clear of count and tick
//   tick        : one-cycle pulse every QTR_DIV enabled cycles
module sccb_qtr_tick #(
  parameter int unsigned QTR_DIV = 63
) (
  input  logic clk_25M,
  input  logic camera_rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CNT_W   = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QTR_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter with registered wrap pulse.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule : sccb_qtr_tick

// File: rtl/sccb_write_master.sv
// SCCB/I2C write engine driven by the OV5640 register-config sequencer.
// Accepts one word {dev_addr, reg_hi, reg_lo, data} per level handshake and
// emits START, NUM_BYTES bytes MSB first with ACK sampling, then STOP.
//   clk_25M     : 25 MHz system clock
//   camera_rstn : asynchronous active-low reset (aborts any transaction)
//   start       : level request, held by the sequencer until tr_end
//   i2c_data    : word to write, first byte in the top bits
//   tr_end      : transaction finished, held until start is seen low
//   ack_err     : a NACK was received during the last transaction
//   busy        : START through STOP in progress
//   i2c_sclk    : SCL, push-pull, idles high
//   i2c_sdat    : SDA, open-drain (drives 0 or Z)
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int unsigned QTR_DIV   = QTR_DIV_DEF,
  parameter int unsigned NUM_BYTES = NUM_BYTES_DEF
) (
  input  logic                   clk_25M,
  input  logic                   camera_rstn,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] i2c_data,
  output logic                   tr_end,
  output logic                   ack_err,
  output logic                   busy,
  output logic                   i2c_sclk,
  inout  wire                    i2c_sdat
);

  localparam int unsigned       SH_W      = 8 * NUM_BYTES;
  localparam int unsigned       BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  logic [STATE_W-1:0] state,    state_nxt;
  logic [1:0]         q,        q_nxt;
  logic [2:0]         bit_cnt,  bit_nxt;
  logic [BYTE_W-1:0]  byte_cnt, byte_nxt;
  logic [SH_W-1:0]    shreg,    sh_nxt;
  logic               sda_drv,  sda_drv_nxt;
  logic               ack_smp,  ack_nxt;
  logic               scl_nxt;
  logic               tr_end_nxt;
  logic               ack_err_nxt;
  logic               busy_nxt;
  logic               sda_oe;
  logic               qtr_tick;

  // Quarter timebase runs only while busy and restarts from zero per transaction.
  sccb_qtr_tick #(
    .QTR_DIV (QTR_DIV)
  ) u_qtr_tick (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .en          (busy),
    .clr         (state == S_IDLE),
    .tick        (qtr_tick)
  );

  // Open-drain SDA: only ever pull low or release.
  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  // State and output registers.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state    <= S_IDLE;
      q        <= Q0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      shreg    <= '0;
      sda_drv  <= 1'b0;
      sda_oe   <= 1'b0;
      ack_smp  <= 1'b0;
      i2c_sclk <= 1'b1;
      tr_end   <= 1'b0;
      ack_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      shreg    <= sh_nxt;
      sda_drv  <= sda_drv_nxt;
      // SDA trails the FSM by one clock so it never moves on the SCL edge.
      sda_oe   <= sda_drv;
      ack_smp  <= ack_nxt;
      i2c_sclk <= scl_nxt;
      tr_end   <= tr_end_nxt;
      ack_err  <= ack_err_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state and output decode. Within each bus state the case on q names
  // the quarter being left; assignments set up the quarter being entered.
  always_comb begin
    state_nxt   = state;
    q_nxt       = q;
    bit_nxt     = bit_cnt;
    byte_nxt    = byte_cnt;
    sh_nxt      = shreg;
    sda_drv_nxt = sda_drv;
    ack_nxt     = ack_smp;
    scl_nxt     = i2c_sclk;
    tr_end_nxt  = tr_end;
    ack_err_nxt = ack_err;
    busy_nxt    = busy;

    case (state)
      S_IDLE: begin
        scl_nxt     = 1'b1;
        sda_drv_nxt = 1'b0;
        tr_end_nxt  = 1'b0;
        busy_nxt    = 1'b0;
        if (start && !tr_end) begin
          sh_nxt      = i2c_data;
          ack_err_nxt = 1'b0;
          busy_nxt    = 1'b1;
          q_nxt       = Q0;
          bit_nxt     = 3'd0;
          byte_nxt    = '0;
          state_nxt   = S_START;
        end
      end

      S_START: begin
        if (qtr_tick) begin
          q_nxt = q + 2'd1;
          case (q)
            Q0: sda_drv_nxt = 1'b1;          // SDA falls while SCL high
            Q1: ;
            Q2: scl_nxt = 1'b0;
            Q3: begin
              sda_drv_nxt = ~shreg[SH_W-1];  // first data bit, SCL low
              state_nxt   = S_BIT;
            end
            default: ;
          endcase
        end
      end

      S_BIT: begin
        if (qtr_tick) begin
          q_nxt = q + 2'd1;
          case (q)
            Q0: ;
            Q1: scl_nxt = 1'b1;
            Q2: ;
            Q3: begin
              scl_nxt = 1'b0;
              sh_nxt  = shreg << 1;
              if (bit_cnt == 3'd7) begin
                bit_nxt     = 3'd0;
                sda_drv_nxt = 1'b0;          // release for the slave ACK
                state_nxt   = S_ACK;
              end else begin
                bit_nxt     = bit_cnt + 3'd1;
                sda_drv_nxt = ~shreg[SH_W-2]; // MSB after this shift
              end
            end
            default: ;
          endcase
        end
      end

      S_ACK: begin
        if (qtr_tick) begin
          q_nxt = q + 2'd1;
          case (q)
            Q0: ;
            Q1: scl_nxt = 1'b1;
            Q2: ack_nxt = i2c_sdat;          // mid-high sample
            Q3: begin
              scl_nxt = 1'b0;
              if (ack_smp) begin
                ack_err_nxt = 1'b1;
                sda_drv_nxt = 1'b1;
                state_nxt   = S_STOP;
              end else if (byte_cnt == LAST_BYTE) begin
                sda_drv_nxt = 1'b1;
                state_nxt   = S_STOP;
              end else begin
                byte_nxt    = byte_cnt + BYTE_W'(1);
                sda_drv_nxt = ~shreg[SH_W-1];
                state_nxt   = S_BIT;
              end
            end
            default: ;
          endcase
        end
      end

      S_STOP: begin
        if (qtr_tick) begin
          q_nxt = q + 2'd1;
          case (q)
            Q0: scl_nxt = 1'b1;
            Q1: sda_drv_nxt = 1'b0;          // SDA rises while SCL high
            Q2: ;
            Q3: begin
              busy_nxt   = 1'b0;
              tr_end_nxt = 1'b1;
              state_nxt  = S_DONE;
            end
            default: ;
          endcase
        end
      end

      S_DONE: begin
        busy_nxt   = 1'b0;
        tr_end_nxt = 1'b1;
        if (!start) begin
          tr_end_nxt = 1'b0;
          state_nxt  = S_IDLE;
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        scl_nxt     = 1'b1;
        sda_drv_nxt = 1'b0;
        busy_nxt    = 1'b0;
        tr_end_nxt  = 1'b0;
      end
    endcase
  end

endmodule : sccb_write_master

// File: tb/tb_sccb_write_master.sv
// Scoreboard bench for sccb_write_master: stimulus pushes expected results,
// a bus decoder reconstructs frames, and a monitor compares at tr_end.
`timescale 1ns/1ps
module tb_sccb_write_master;
  import sccb_pkg::*;

  localparam int unsigned QD      = 63;
  localparam longint      CLK_PER = 40;

  typedef struct {
    longint      t0;
    int          lat;
    int          nbytes;
    logic [31:0] bytes;
    logic        aerr;
  } exp_t;

  typedef struct {
    int          nbytes;
    logic [31:0] bytes;
  } obs_t;

  logic        clk_25M = 1'b0;
  logic        camera_rstn;
  logic        start;
  logic [31:0] i2c_data;
  logic        tr_end;
  logic        ack_err;
  logic        busy;
  logic        i2c_sclk;
  wire         i2c_sdat;
  logic        slave_drv = 1'b0;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int     nack_byte = -1;

  exp_t exp_q[$];
  obs_t obs_q[$];

  assign i2c_sdat = slave_drv ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  sccb_write_master dut (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .start       (start),
    .i2c_data    (i2c_data),
    .tr_end      (tr_end),
    .ack_err     (ack_err),
    .busy        (busy),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat    (i2c_sdat)
  );

  always #20 clk_25M = ~clk_25M;
  always @(posedge clk_25M) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Bus decoder and slave model: START/STOP detection, bit capture on SCL
  // rise, ACK drive on SCL fall, SCL high-time measurement.
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;
  logic        in_frame = 1'b0;
  logic        start_flag = 1'b0;
  int          bitn = 0;
  int          nby = 0;
  logic [7:0]  sr = 8'h00;
  logic [31:0] obytes = 32'h0;
  longint      t_rise = 0;
  obs_t        o_new;

  always @(i2c_sclk or i2c_sdat or camera_rstn) begin
    if (!camera_rstn) begin
      in_frame   = 1'b0;
      start_flag = 1'b0;
      slave_drv  = 1'b0;
      bitn       = 0;
    end else begin
      if (i2c_sdat != p_sda && i2c_sclk && p_scl) begin
        if (!i2c_sdat) begin
          chk("start_outside_frame", in_frame, 0);
          in_frame   = 1'b1;
          start_flag = 1'b1;
          bitn       = 0;
          nby        = 0;
          obytes     = 32'h0;
        end else begin
          chk("stop_inside_frame", in_frame, 1);
          if (in_frame) begin
            chk("stop_bit_alignment", bitn, 1);
            o_new.nbytes = nby;
            o_new.bytes  = obytes;
            obs_q.push_back(o_new);
          end
          in_frame = 1'b0;
          bitn     = 0;
        end
      end
      if (i2c_sclk && !p_scl) begin
        t_rise = $time;
        if (in_frame) begin
          if (bitn < 8) sr = {sr[6:0], i2c_sdat};
          bitn++;
        end
      end
      if (!i2c_sclk && p_scl) begin
        if (start_flag) start_flag = 1'b0;
        else chk("scl_high_cycles", ($time - t_rise) / CLK_PER, 2 * QD);
        if (in_frame && bitn == 8) begin
          obytes    = {obytes[23:0], sr};
          nby++;
          slave_drv = (nack_byte != nby - 1);
        end else if (in_frame && bitn == 9) begin
          slave_drv = 1'b0;
          bitn      = 0;
        end
      end
    end
    p_scl = i2c_sclk;
    p_sda = i2c_sdat;
  end

  // Scoreboard monitor: on each tr_end rise, pop expected and observed.
  logic p_tr_end = 1'b0;
  exp_t e_cur;
  obs_t o_cur;

  always @(negedge clk_25M) begin
    if (camera_rstn && tr_end && !p_tr_end) begin
      chk("tr_end_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e_cur = exp_q.pop_front();
        chk("latency", cyc - e_cur.t0, e_cur.lat);
        chk("ack_err", ack_err, e_cur.aerr);
        chk("busy_at_done", busy, 0);
        chk("frame_seen", obs_q.size() > 0, 1);
        if (obs_q.size() > 0) begin
          o_cur = obs_q.pop_front();
          chk("byte_count", o_cur.nbytes, e_cur.nbytes);
          chk("bytes", o_cur.bytes, e_cur.bytes);
        end
      end
    end
    p_tr_end = tr_end;
  end

  task automatic issue(input logic [31:0] d, input int nk, input int exp_nb,
                       input logic [31:0] exp_bytes, input logic exp_aerr,
                       input int exp_lat);
    exp_t e;
    @(negedge clk_25M);
    nack_byte = nk;
    i2c_data  = d;
    start     = 1'b1;
    e.t0      = cyc + 1;
    e.lat     = exp_lat;
    e.nbytes  = exp_nb;
    e.bytes   = exp_bytes;
    e.aerr    = exp_aerr;
    exp_q.push_back(e);
  endtask

  task automatic wait_tr_end(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (tr_end !== lvl && n < budget) begin
      @(negedge clk_25M);
      n++;
    end
    if (tr_end !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: tr_end not %0b within %0d cycles", name, lvl, budget);
    end
  endtask

  // Drop start at the tr_end negedge; tr_end must clear one clock later.
  task automatic release_start(input string name);
    start = 1'b0;
    @(negedge clk_25M);
    chk(name, tr_end, 0);
  endtask

  int bad;

  initial begin
    camera_rstn = 1'b0;
    start       = 1'b0;
    i2c_data    = 32'h0;
    repeat (3) @(negedge clk_25M);
    chk("rst_scl", i2c_sclk, 1);
    chk("rst_sda", i2c_sdat, 1);
    chk("rst_tr_end", tr_end, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_busy", busy, 0);
    camera_rstn = 1'b1;
    repeat (3) @(negedge clk_25M);

    // Full write, slave ACKs every byte.
    issue({OV5640_WR_ADDR, 24'h30_0882}, -1, 4, 32'h7830_0882, 1'b0, 9577);
    wait_tr_end(1'b1, 12000, "full_write_done");
    release_start("full_tr_end_fall");

    // NACK on the address byte, then hold start long after tr_end.
    issue({OV5640_WR_ADDR, 24'h30_0882}, 0, 1, 32'h0000_0078, 1'b1, 2773);
    wait_tr_end(1'b1, 4000, "nack_done");
    bad = 0;
    repeat (20000) begin
      @(negedge clk_25M);
      if (busy !== 1'b0 || tr_end !== 1'b1 || ack_err !== 1'b1) bad++;
    end
    chk("hold_no_retrigger", bad, 0);
    release_start("hold_tr_end_fall");

    // New transaction clears ack_err; reset it during the third byte.
    @(negedge clk_25M);
    nack_byte = -1;
    i2c_data  = {OV5640_WR_ADDR, 24'h30_0a0b};
    start     = 1'b1;
    @(negedge clk_25M);
    chk("restart_busy", busy, 1);
    chk("restart_ack_err_clear", ack_err, 0);
    repeat (90 * QD) @(negedge clk_25M);
    chk("pre_reset_busy", busy, 1);
    #5 camera_rstn = 1'b0;
    #1;
    chk("abort_scl", i2c_sclk, 1);
    chk("abort_sda", i2c_sdat, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tr_end", tr_end, 0);
    start = 1'b0;
    repeat (3) @(negedge clk_25M);
    camera_rstn = 1'b1;
    repeat (2) @(negedge clk_25M);

    // Back-to-back sequencer words after reset.
    issue({OV5640_WR_ADDR, 24'h31_0311}, -1, 4, 32'h7831_0311, 1'b0, 9577);
    wait_tr_end(1'b1, 12000, "b2b0_done");
    start = 1'b0;
    wait_tr_end(1'b0, 10, "b2b0_release");
    issue({OV5640_WR_ADDR, 24'h30_0882}, -1, 4, 32'h7830_0882, 1'b0, 9577);
    wait_tr_end(1'b1, 12000, "b2b1_done");
    start = 1'b0;
    wait_tr_end(1'b0, 10, "b2b1_release");
    issue({OV5640_WR_ADDR, 24'h30_0842}, -1, 4, 32'h7830_0842, 1'b0, 9577);
    wait_tr_end(1'b1, 12000, "b2b2_done");
    release_start("b2b2_tr_end_fall");

    repeat (10) @(negedge clk_25M);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frames_drained", obs_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sccb_write_master
